instr_encoder_loader: RTL and testbench

Program loader for the RV32I pipeline: accepts instructions as decoded fields (class, registers, funct3, immediate) over a valid/ready stream, encodes each into a 32-bit RV32I word, and writes the words sequentially into instruction memory. It covers exactly the opcodes and branch types the pipeline's main decoder supports. It rejects anything the core cannot execute. When the last instruction has been written, it releases the core with `cpu_run`. It sits between the test/boot host and the instruction memory write port.

---
 rtl/instr_encoder_loader.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes decoded RV32I instruction fields into 32-bit words
// and writes them sequentially into instruction memory, then releases the core.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic [ADDR_W:0]   prog_len,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]  state;
  logic [1:0]  nextState;
  logic        instrLegal;
  logic [31:0] encWord;
  logic        immFits;
  logic        handshake;
  logic        lastQ;
  logic        memFull;

  assign handshake = in_valid & in_ready;
  assign immFits   = (in_imm[12] == in_imm[11]);
  assign memFull   = (imem_addr == ADDR_MAX);

  // Encode the incoming fields and decide whether the core can execute them
  always_comb begin
    instrLegal = 1'b0;
    encWord    = '0;
    case (in_class)
      3'd0: begin
        instrLegal = 1'b1;
        encWord    = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      3'd1: begin
        instrLegal = immFits;
        encWord    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      end
      3'd2: begin
        instrLegal = immFits && (in_funct3 == 3'b010);
        encWord    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      end
      3'd3: begin
        instrLegal = immFits && (in_funct3 == 3'b010);
        encWord    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      end
      3'd4: begin
        // BEQ/BNE/BLT/BGE are exactly the funct3 codes with bit 1 clear
        instrLegal = !in_imm[0] && !in_funct3[1];
        encWord    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], OP_BRANCH};
      end
      default: begin
        instrLegal = 1'b0;
        encWord    = '0;
      end
    endcase
  end

  // Next-state logic; start restarts the load from any state
  always_comb begin
    nextState = state;
    if (start) begin
      nextState = ACCEPT;
    end else begin
      case (state)
        IDLE:    nextState = IDLE;
        ACCEPT: begin
          if (handshake) begin
            if (instrLegal)   nextState = WRITE;
            else if (in_last) nextState = RUN;
          end
        end
        WRITE:   nextState = (lastQ || memFull) ? RUN : ACCEPT;
        RUN:     nextState = RUN;
        default: nextState = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Registered outputs, write pointer and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      prog_len   <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
      lastQ      <= 1'b0;
    end else begin
      in_ready <= (nextState == ACCEPT);
      imem_we  <= (nextState == WRITE);
      cpu_run  <= (nextState == RUN);
      if (start) begin
        imem_addr <= BASE;
        prog_len  <= '0;
        err       <= 1'b0;
        err_cnt   <= '0;
        lastQ     <= 1'b0;
      end else begin
        if (state == ACCEPT && handshake) begin
          lastQ <= in_last;
          if (instrLegal) begin
            imem_wdata <= encWord;
          end else begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        if (state == WRITE) begin
          imem_addr <= imem_addr + ADDR_W'(1);
          prog_len  <= prog_len + LEN_W'(1);
          if (!lastQ && memFull) err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: driver feeds instructions and
// pushes expected writes; a monitor pops and compares on every imem_we.
module tb_instr_encoder_loader;

  localparam int unsigned AW   = 4;
  localparam int unsigned BASE = 3;
  localparam int unsigned MEMW = 1 << AW;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [12:0] imm;
    logic        last;
  } ins_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic          in_alt;
  logic [12:0]   in_imm;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic [AW:0]   prog_len;
  logic          err;
  logic [7:0]    err_cnt;

  int nVec  = 0;
  int nMiss = 0;

  wr_t expQ[$];
  int  mPtr;
  int  mLen;
  int  mErrCnt;
  bit  mErr;
  bit  mDone;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .prog_len(prog_len), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: is the instruction executable by the core
  function automatic bit refLegal(input ins_t x);
    int v;
    bit fits;
    v    = int'($signed(x.imm));
    fits = (v >= -2048) && (v <= 2047);
    case (x.cls)
      3'd0:       return 1'b1;
      3'd1:       return fits;
      3'd2, 3'd3: return fits && (x.f3 == 3'd2);
      3'd4:       return ((v % 2) == 0) && (x.f3 == 3'd0 || x.f3 == 3'd1 ||
                                            x.f3 == 3'd4 || x.f3 == 3'd5);
      default:    return 1'b0;
    endcase
  endfunction

  // Reference: instruction word built by shifting fields into place
  function automatic logic [31:0] refEncode(input ins_t x);
    int unsigned rd, rs1, rs2, f3, imm, w;
    rd  = 32'(x.rd);
    rs1 = 32'(x.rs1);
    rs2 = 32'(x.rs2);
    f3  = 32'(x.f3);
    imm = 32'(x.imm);
    w   = (f3 << 12) | (rs1 << 15);
    case (x.cls)
      3'd0: w = w | 32'h33 | (rd << 7) | (rs2 << 20) | (32'(x.alt) << 30);
      3'd1: w = w | 32'h13 | (rd << 7) | ((imm & 32'hFFF) << 20);
      3'd2: w = w | 32'h03 | (rd << 7) | ((imm & 32'hFFF) << 20);
      3'd3: w = w | 32'h23 | ((imm & 32'h1F) << 7) | (rs2 << 20) | (((imm >> 5) & 32'h7F) << 25);
      default: w = w | 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                   | (rs2 << 20) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
    endcase
    return w;
  endfunction

  // Model reaction to one handshaken instruction
  function automatic void modelAccept(input ins_t x);
    wr_t e;
    bit  wasFull;
    if (!refLegal(x)) begin
      mErr = 1'b1;
      if (mErrCnt < 255) mErrCnt++;
      if (x.last) mDone = 1'b1;
      return;
    end
    e.addr = AW'(mPtr);
    e.data = refEncode(x);
    expQ.push_back(e);
    wasFull = (mPtr == int'(MEMW) - 1);
    mPtr    = (mPtr + 1) % int'(MEMW);
    mLen++;
    if (x.last) mDone = 1'b1;
    else if (wasFull) begin
      mErr  = 1'b1;
      mDone = 1'b1;
    end
  endfunction

  function automatic void modelClear();
    mPtr = int'(BASE); mLen = 0; mErrCnt = 0; mErr = 1'b0; mDone = 1'b0;
  endfunction

  function automatic ins_t mk(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                              input logic [12:0] imm, input logic last);
    ins_t x;
    x.cls = c; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.f3 = f3;
    x.alt = alt; x.imm = imm; x.last = last;
    return x;
  endfunction

  function automatic ins_t randInstr();
    ins_t x;
    x.cls = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    x.rd  = 5'($urandom); x.rs1 = 5'($urandom); x.rs2 = 5'($urandom);
    x.alt = 1'($urandom);
    x.f3  = 3'($urandom);
    if ((x.cls == 3'd2 || x.cls == 3'd3) && $urandom_range(0, 3) != 0) x.f3 = 3'd2;
    x.imm = 13'($urandom);
    if ($urandom_range(0, 3) != 0) x.imm[12] = x.imm[11];
    if (x.cls == 3'd4 && $urandom_range(0, 3) != 0) x.imm[0] = 1'b0;
    x.last = 1'b0;
    return x;
  endfunction

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (expQ.size() == 0) begin
        nVec++; nMiss++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  // Called just after a negedge: issue one instruction and check the cycle timing
  task automatic sendInstr(input ins_t x);
    int  waitCnt;
    bit  legal;
    in_class = x.cls; in_rd = x.rd; in_rs1 = x.rs1; in_rs2 = x.rs2;
    in_funct3 = x.f3; in_alt = x.alt; in_imm = x.imm; in_last = x.last;
    in_valid = 1'b1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      mDone = 1'b1;
      return;
    end
    @(posedge clk);
    legal = refLegal(x);
    modelAccept(x);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_t1", 32'(in_ready), 32'(!legal && !mDone));
    chk("run_t1", 32'(cpu_run), 32'(!legal && mDone));
    if (legal) begin
      @(negedge clk);
      chk("ready_t2", 32'(in_ready), 32'(!mDone));
      chk("run_t2", 32'(cpu_run), 32'(mDone));
    end
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    modelClear();
    expQ.delete();
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_run", 32'(cpu_run), 32'd0);
    chk("start_len", 32'(prog_len), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_errcnt", 32'(err_cnt), 32'd0);
    chk("start_addr", 32'(imem_addr), BASE);
  endtask

  task automatic checkEnd();
    chk("end_run", 32'(cpu_run), 32'd1);
    chk("end_len", 32'(prog_len), 32'(mLen));
    chk("end_err", 32'(err), 32'(mErr));
    chk("end_errcnt", 32'(err_cnt), 32'(mErrCnt));
    chk("end_pending", 32'(expQ.size()), 32'd0);
  endtask

  task automatic runRandomProgram(input int n);
    ins_t x;
    for (int i = 0; i < n && !mDone; i++) begin
      x = randInstr();
      x.last = (i == n - 1);
      sendInstr(x);
    end
    checkEnd();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t x;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_alt = 1'b0; in_imm = '0; in_last = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_len", 32'(prog_len), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);

    // Directed stream: I, R add, R sub, STORE, LOAD, BRANCH (last)
    doStart();
    sendInstr(mk(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5, 1'b0));
    sendInstr(mk(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b0));
    sendInstr(mk(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0, 1'b0));
    sendInstr(mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 13'd8, 1'b0));
    sendInstr(mk(3'd2, 5'd5, 5'd1, 5'd0, 3'd2, 1'b0, 13'h1FFC, 1'b0));
    sendInstr(mk(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b1));
    checkEnd();
    chk("stream_len", 32'(prog_len), 32'd6);

    // Restart from RUN, then back-to-back rejects followed by a legal last
    doStart();
    sendInstr(mk(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0, 1'b0));
    sendInstr(mk(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd3, 1'b0));
    sendInstr(mk(3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 13'd8, 1'b0));
    sendInstr(mk(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'h0800, 1'b0));
    sendInstr(mk(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 13'd7, 1'b1));
    checkEnd();
    chk("reject_errcnt", 32'(err_cnt), 32'd4);

    // Restart while accepting: the new load begins at the base address
    doStart();
    sendInstr(mk(3'd1, 5'd4, 5'd4, 5'd0, 3'd1, 1'b0, 13'd9, 1'b0));
    doStart();
    sendInstr(mk(3'd0, 5'd7, 5'd8, 5'd9, 3'd7, 1'b0, 13'd0, 1'b1));
    checkEnd();

    // Memory full: base 3 in a 16-word memory leaves room for 13 words
    doStart();
    for (int i = 0; i < 20 && !mDone; i++)
      sendInstr(mk(3'd1, 5'(i), 5'd1, 5'd0, 3'd0, 1'b0, 13'(i), 1'b0));
    checkEnd();
    chk("full_len", 32'(prog_len), 32'd13);
    chk("full_err", 32'(err), 32'd1);

    // Reject counter saturation
    doStart();
    for (int i = 0; i < 260; i++)
      sendInstr(mk(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0, 1'(i == 259)));
    checkEnd();
    chk("sat_errcnt", 32'(err_cnt), 32'd255);

    // Randomized programs
    for (int p = 0; p < 20; p++) begin
      doStart();
      runRandomProgram($urandom_range(1, 20));
    end

    // Reset asserted while a write is on the bus
    doStart();
    x = mk(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 13'd0, 1'b0);
    in_class = x.cls; in_rd = x.rd; in_rs1 = x.rs1; in_rs2 = x.rs2;
    in_funct3 = x.f3; in_alt = x.alt; in_imm = x.imm; in_last = x.last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_run", 32'(cpu_run), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_len", 32'(prog_len), 32'd0);
    expQ.delete();
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd0);
      chk("idle_we", 32'(imem_we), 32'd0);
    end
    in_valid = 1'b0;
    doStart();
    sendInstr(mk(3'd2, 5'd6, 5'd7, 5'd0, 3'd2, 1'b0, 13'h1800, 1'b1));
    checkEnd();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
